// File: rtl/des_sbox_unit.sv
// des_sbox_unit: multi-cycle DES S1..S8 substitution, LANES boxes per clock; `DES_SBOX_PERM_EN adds the P permutation on sout
module des_sbox_unit #(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] sin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sout,
  output logic        busy
);
  localparam int NG = 8 / LANES;
  localparam int CW = NG > 1 ? $clog2(NG) : 1;
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
  end
  state_t            state_q, state_d;
  logic [47:0]       sh_q, sh_d;
  logic [31:0]       res_q, res_d;
  logic [31:0]       out_q, out_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*LANES-1:0] look;
  logic              accept, last;
  // Each table holds 64 nibbles, row-major, so entry {row,col} sits at nibble index {b5,b0,b4..b1} from the MSB
  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
    logic [255:0] t;
    logic [5:0]   idx;
    t   = SB[n];
    idx = {b[5], b[0], b[4:1]};
    return t[{~idx, 2'b00} +: 4];
  endfunction
  assign in_ready  = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
  assign out_valid = state_q == DONE;
  assign busy      = state_q == BUSY;
  assign accept    = in_valid && in_ready;
  assign last      = cnt_q == CW'(NG - 1);
  // Next state: accept (from IDLE or a DONE release) restarts; BUSY consumes LANES groups per edge
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    look    = '0;
    for (int j = 0; j < LANES; j++)
      look[4*(LANES-1-j) +: 4] = sbox(3'(int'(cnt_q) * LANES + j), sh_q[47-6*j -: 6]);
    if (accept) begin
      state_d = BUSY;
      sh_d    = sin;
      res_d   = '0;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      sh_d  = sh_q << (6 * LANES);
      res_d = 32'({res_q, look});
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        out_d   = res_d;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // State and datapath registers, all cleared by reset so an in-flight word is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef DES_SBOX_PERM_EN
  localparam int P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                            2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  for (genvar i = 0; i < 32; i++) begin : g_perm
    assign sout[31-i] = out_q[32-P[i]];
  end
`else
  assign sout = out_q;
`endif
endmodule

// File: tb/tb_des_sbox_unit.sv
// tb_des_sbox_unit: scoreboard bench over one instance per legal LANES value
module tb_des_sbox_unit;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] in_valid = '0, out_ready = '0;
  logic [3:0] in_ready, out_valid, busy;
  logic [3:0][47:0] sin = '0;
  logic [3:0][31:0] sout;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_unit #(.LANES(1 << g)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .sin(sin[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .sout(sout[g]),
      .busy(busy[g])
    );
  end

  int S [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };
  int P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                 2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  function automatic logic [31:0] model(input logic [47:0] w);
    logic [31:0] r, p;
    logic [5:0] b;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      b = w[47-6*k -: 6];
      r = {r[27:0], 4'(S[k][int'({b[5], b[0]}) * 16 + int'(b[4:1])])};
    end
    p = r;
`ifdef DES_SBOX_PERM_EN
    for (int i = 1; i <= 32; i++) p[32-i] = r[32-P[i-1]];
`endif
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int l, output int n, output int b);
    n = 0;
    b = 0;
    while (!out_valid[l] && n < 40) begin
      b += int'(busy[l]);
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1;
    step();
    n_chk++;
    if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready_low: got %b expected 0000", in_ready); end
    step();
    rst = 0;
    step();
    n_chk++;
    if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
    n_chk++;
    if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    n_chk++;
    if (in_ready !== 4'b1111) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1111", in_ready); end
    for (int l = 0; l < 4; l++) begin
      e = '0;
      n_chk++;
      if (sout[l] !== e) begin n_fail++; $display("FAIL reset_sout[%0d]: got %h expected %h", l, sout[l], e); end
    end
  endtask

  task automatic test_lanes8_zero();
    int n, b;
    logic [31:0] e;
`ifdef DES_SBOX_PERM_EN
    exp_q.push_back(model(48'h0));
`else
    exp_q.push_back(32'hEFA72C4D);
`endif
    in_valid[3] = 1; sin[3] = 48'h0; out_ready[3] = 0;
    step();
    in_valid[3] = 0;
    wait_out(3, n, b);
    n_chk++;
    if (n !== 1) begin n_fail++; $display("FAIL l8_latency: got %0d expected 1", n); end
    n_chk++;
    if (b !== 1) begin n_fail++; $display("FAIL l8_busy_cycles: got %0d expected 1", b); end
    n_chk++;
    if (in_ready[3] !== 1'b0) begin n_fail++; $display("FAIL l8_done_in_ready: got %b expected 0", in_ready[3]); end
    e = exp_q.pop_front();
    n_chk++;
    if (sout[3] !== e) begin n_fail++; $display("FAIL l8_sout: got %h expected %h", sout[3], e); end
    out_ready[3] = 1;
    step();
    out_ready[3] = 0;
    n_chk++;
    if (out_valid[3] !== 1'b0 || busy[3] !== 1'b0) begin n_fail++; $display("FAIL l8_release: got valid %b busy %b expected 0 0", out_valid[3], busy[3]); end
    n_chk++;
    if (sout[3] !== e) begin n_fail++; $display("FAIL l8_sout_hold: got %h expected %h", sout[3], e); end
  endtask

  task automatic test_lanes1_vector();
    int n, b;
    logic [31:0] e;
`ifdef DES_SBOX_PERM_EN
    exp_q.push_back(32'h234AA9BB);
`else
    exp_q.push_back(32'h5C82B597);
`endif
    in_valid[0] = 1; sin[0] = 48'h6117BA866527; out_ready[0] = 0;
    step();
    in_valid[0] = 0;
    wait_out(0, n, b);
    n_chk++;
    if (n !== 8) begin n_fail++; $display("FAIL l1_latency: got %0d expected 8", n); end
    n_chk++;
    if (b !== 8) begin n_fail++; $display("FAIL l1_busy_cycles: got %0d expected 8", b); end
    e = exp_q.pop_front();
    n_chk++;
    if (sout[0] !== e) begin n_fail++; $display("FAIL l1_sout: got %h expected %h", sout[0], e); end
    out_ready[0] = 1;
    step();
    out_ready[0] = 0;
    n_chk++;
    if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL l1_release: got %b expected 0", out_valid[0]); end
  endtask

  task automatic test_back_to_back();
    int n, b;
    logic [31:0] e;
    exp_q.push_back(model(48'h6117BA866527));
    in_valid[1] = 1; sin[1] = 48'h6117BA866527; out_ready[1] = 0;
    step();
    in_valid[1] = 0;
    wait_out(1, n, b);
    n_chk++;
    if (n !== 4) begin n_fail++; $display("FAIL l2_latency_a: got %0d expected 4", n); end
    e = exp_q[0];
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || sout[1] !== e) begin
        n_fail++;
        $display("FAIL l2_stall[%0d]: got valid %b ready %b sout %h expected 1 0 %h", c, out_valid[1], in_ready[1], sout[1], e);
      end
      step();
    end
    in_valid[1] = 1; sin[1] = 48'h0; out_ready[1] = 1;
    #1;
    n_chk++;
    if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL l2_release_ready: got %b expected 1", in_ready[1]); end
    e = exp_q.pop_front();
    n_chk++;
    if (sout[1] !== e) begin n_fail++; $display("FAIL l2_sout_a: got %h expected %h", sout[1], e); end
`ifdef DES_SBOX_PERM_EN
    exp_q.push_back(model(48'h0));
`else
    exp_q.push_back(32'hEFA72C4D);
`endif
    step();
    in_valid[1] = 0; out_ready[1] = 0;
    n_chk++;
    if (out_valid[1] !== 1'b0 || busy[1] !== 1'b1) begin n_fail++; $display("FAIL l2_rearm: got valid %b busy %b expected 0 1", out_valid[1], busy[1]); end
    wait_out(1, n, b);
    n_chk++;
    if (n !== 4) begin n_fail++; $display("FAIL l2_latency_b: got %0d expected 4", n); end
    e = exp_q.pop_front();
    n_chk++;
    if (sout[1] !== e) begin n_fail++; $display("FAIL l2_sout_b: got %h expected %h", sout[1], e); end
    out_ready[1] = 1;
    step();
    out_ready[1] = 0;
  endtask

  task automatic test_reset_midflight();
    int n, b;
    logic [31:0] e;
    in_valid[2] = 1; sin[2] = 48'hA5C3_0F1E_7788; out_ready[2] = 1;
    step();
    in_valid[2] = 0;
    wait_out(2, n, b);
    step();
    out_ready[2] = 0;
    in_valid[2] = 1; sin[2] = 48'h0;
    step();
    in_valid[2] = 0;
    rst = 1;
    step();
    rst = 0;
    e = '0;
    n_chk++;
    if (out_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin n_fail++; $display("FAIL l4_rst_state: got valid %b busy %b expected 0 0", out_valid[2], busy[2]); end
    n_chk++;
    if (sout[2] !== e) begin n_fail++; $display("FAIL l4_rst_sout: got %h expected %h", sout[2], e); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++;
      if (out_valid[2] !== 1'b0) begin n_fail++; $display("FAIL l4_no_output[%0d]: got %b expected 0", c, out_valid[2]); end
    end
`ifdef DES_SBOX_PERM_EN
    exp_q.push_back(32'h234AA9BB);
`else
    exp_q.push_back(32'h5C82B597);
`endif
    in_valid[2] = 1; sin[2] = 48'h6117BA866527;
    step();
    in_valid[2] = 0;
    wait_out(2, n, b);
    n_chk++;
    if (n !== 2) begin n_fail++; $display("FAIL l4_latency: got %0d expected 2", n); end
    e = exp_q.pop_front();
    n_chk++;
    if (sout[2] !== e) begin n_fail++; $display("FAIL l4_sout: got %h expected %h", sout[2], e); end
    out_ready[2] = 1;
    step();
    out_ready[2] = 0;
  endtask

  task automatic test_random();
    int sent, got, cyc;
    logic have;
    logic [47:0] w;
    logic [31:0] e;
    for (int l = 0; l < 4; l++) begin
      sent = 0; got = 0; cyc = 0; have = 0; w = '0;
      exp_q.delete();
      while ((sent < 250 || got < 250) && cyc < 8000) begin
        if (!have && sent < 250) begin
          w = {16'($urandom), $urandom};
          have = 1;
        end
        in_valid[l]  = have && ($urandom_range(0, 3) != 0);
        sin[l]       = w;
        out_ready[l] = $urandom_range(0, 2) != 0;
        #1;
        if (out_valid[l] && out_ready[l]) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_l%0d_extra: got %h expected no output", l, sout[l]);
          end else begin
            e = exp_q.pop_front();
            if (sout[l] !== e) begin n_fail++; $display("FAIL rand_l%0d_word%0d: got %h expected %h", l, got, sout[l], e); end
          end
          got++;
        end
        if (in_valid[l] && in_ready[l]) begin
          exp_q.push_back(model(w));
          sent++;
          have = 0;
        end
        step();
        cyc++;
      end
      in_valid[l] = 0; out_ready[l] = 0;
      n_chk++;
      if (got !== 250 || sent !== 250 || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL rand_l%0d_count: got sent %0d recv %0d pending %0d expected 250 250 0", l, sent, got, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lanes8_zero();
    test_lanes1_vector();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
